// File: rtl/tl_left_phase_scheduler.sv
// Two-road traffic light sequencer with protected left-turn phases.
// Moore FSM with a dwell timer; optional all-red clearance via TL_ALL_RED_EN.
//
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   ta/tal   road A through / left request
//   tb/tbl   road B through / left request
//   la/lb    road lights: 00 green, 01 yellow, 10 left, 11 red
//   phase    current phase code S0..S7
//   allred   high during all-red clearance (tied 0 without TL_ALL_RED_EN)
//
// Macro TL_ALL_RED_EN: inserts ALLRED_LEN cycles of all-red between roads.
module tl_left_phase_scheduler #(
    parameter int GREEN_MIN  = 4,
    parameter int GREEN_MAX  = 16,
    parameter int YELLOW_LEN = 2,
    parameter int ALLRED_LEN = 1,
    parameter int TW         = 5
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ta,
    input  logic       tal,
    input  logic       tb,
    input  logic       tbl,
    output logic [1:0] la,
    output logic [1:0] lb,
    output logic [2:0] phase,
    output logic       allred
);

`ifdef TL_ALL_RED_EN
    // Clearance states remember which yellow they follow so that phase
    // keeps showing that yellow code while all-red is active.
    typedef enum logic [3:0] {
        S0     = 4'd0,
        S1     = 4'd1,
        S2     = 4'd2,
        S3     = 4'd3,
        S4     = 4'd4,
        S5     = 4'd5,
        S6     = 4'd6,
        S7     = 4'd7,
        AR_AB1 = 4'd8,
        AR_AB3 = 4'd9,
        AR_BA5 = 4'd10,
        AR_BA7 = 4'd11
    } state_e;
`else
    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4,
        S5 = 3'd5,
        S6 = 3'd6,
        S7 = 3'd7
    } state_e;
`endif

    localparam logic [TW-1:0] T_SAT  = {TW{1'b1}};
    localparam logic [TW-1:0] T_GMIN = TW'(GREEN_MIN - 1);
    localparam logic [TW-1:0] T_GMAX = TW'(GREEN_MAX - 1);
    localparam logic [TW-1:0] T_YEL  = TW'(YELLOW_LEN - 1);

    state_e        state_q, state_d;
    logic [TW-1:0] t_q, t_d;

    logic gmin;
    logic gmax;
    logic ydone;
    logic a_req;
    logic b_req;

    assign gmin  = (t_q >= T_GMIN);
    assign gmax  = (t_q >= T_GMAX);
    assign ydone = (t_q == T_YEL);
    assign a_req = ta | tal;
    assign b_req = tb | tbl;

`ifdef TL_ALL_RED_EN
    localparam logic [TW-1:0] T_AR = TW'(ALLRED_LEN - 1);
    logic ardone;
    assign ardone = (t_q == T_AR);
`endif

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S0: begin
                if (gmin && (!ta || (gmax && b_req)))
                    state_d = S1;
            end
            S1: begin
                if (ydone) begin
`ifdef TL_ALL_RED_EN
                    state_d = tal ? S2 : AR_AB1;
`else
                    state_d = tal ? S2 : S4;
`endif
                end
            end
            S2: begin
                if (gmin && (!tal || (gmax && b_req)))
                    state_d = S3;
            end
            S3: begin
                if (ydone) begin
`ifdef TL_ALL_RED_EN
                    state_d = AR_AB3;
`else
                    state_d = S4;
`endif
                end
            end
            S4: begin
                if (gmin && (!tb || (gmax && a_req)))
                    state_d = S5;
            end
            S5: begin
                if (ydone) begin
`ifdef TL_ALL_RED_EN
                    state_d = tbl ? S6 : AR_BA5;
`else
                    state_d = tbl ? S6 : S0;
`endif
                end
            end
            S6: begin
                if (gmin && (!tbl || (gmax && a_req)))
                    state_d = S7;
            end
            S7: begin
                if (ydone) begin
`ifdef TL_ALL_RED_EN
                    state_d = AR_BA7;
`else
                    state_d = S0;
`endif
                end
            end
`ifdef TL_ALL_RED_EN
            AR_AB1, AR_AB3: begin
                if (ardone)
                    state_d = S4;
            end
            AR_BA5, AR_BA7: begin
                if (ardone)
                    state_d = S0;
            end
`endif
            default: state_d = S0;
        endcase
    end

    // Dwell timer restarts at 0 on every state change and saturates.
    always_comb begin
        t_d = t_q;
        if (state_d != state_q)
            t_d = '0;
        else if (t_q != T_SAT)
            t_d = t_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S0;
            t_q     <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
        end
    end

    // Output decode from registered state only
    always_comb begin
        la     = 2'b11;
        lb     = 2'b11;
        phase  = 3'd0;
        allred = 1'b0;
        unique case (state_q)
            S0: begin la = 2'b00; phase = 3'd0; end
            S1: begin la = 2'b01; phase = 3'd1; end
            S2: begin la = 2'b10; phase = 3'd2; end
            S3: begin la = 2'b01; phase = 3'd3; end
            S4: begin lb = 2'b00; phase = 3'd4; end
            S5: begin lb = 2'b01; phase = 3'd5; end
            S6: begin lb = 2'b10; phase = 3'd6; end
            S7: begin lb = 2'b01; phase = 3'd7; end
`ifdef TL_ALL_RED_EN
            AR_AB1: begin allred = 1'b1; phase = 3'd1; end
            AR_AB3: begin allred = 1'b1; phase = 3'd3; end
            AR_BA5: begin allred = 1'b1; phase = 3'd5; end
            AR_BA7: begin allred = 1'b1; phase = 3'd7; end
`endif
            default: begin
                la    = 2'b11;
                lb    = 2'b11;
                phase = 3'd0;
            end
        endcase
    end

endmodule
